// File: rtl/usb2_ext_in_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : usb2_ext_in_arbiter
//  Description : Round-robin arbiter sharing the usb2 external IN-endpoint
//                buffer port between NUM_REQ byte-stream requesters. Streams
//                the granted packet into the buffer from address 0, commits
//                it with its length and waits for the acknowledge. Packets
//                longer than MAX_LEN are committed as MAX_LEN-sized pieces
//                without releasing the grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb2_ext_in_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_LEN     = 512,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                   ext_clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic [8:0]             buf_in_addr,
    output logic [7:0]             buf_in_data,
    output logic                   buf_in_wren,
    input  logic                   buf_in_ready,
    output logic                   buf_in_commit,
    output logic [9:0]             buf_in_commit_len,
    input  logic                   buf_in_commit_ack,
    output logic                   busy,
    output logic                   err_ack_timeout
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_RDY = 2'd1;
    localparam logic [1:0] S_XFER     = 2'd2;
    localparam logic [1:0] S_WAIT_ACK = 2'd3;

    localparam logic [9:0]       LAST_IDX = 10'(MAX_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] owner_inc;
    logic [PTR_W-1:0] arb_idx;
    logic [PTR_W-1:0] arb_hi_idx;
    logic [PTR_W-1:0] arb_any_idx;
    logic             arb_hi_found;
    logic [9:0]       count;
    logic             split;
    logic [TMR_W-1:0] ack_timer;
    logic [7:0]       owner_data;
    logic             owner_valid;
    logic             owner_last;
    logic             hs;
    logic             xfer_end;
    logic             ack_expired;
    logic             start;

    // Round-robin pick: lowest valid index at/above rr_ptr, else lowest valid overall (wrap)
    always_comb begin
        arb_hi_found = 1'b0;
        arb_hi_idx   = '0;
        arb_any_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                arb_any_idx = PTR_W'(i);
                if (PTR_W'(i) >= rr_ptr) begin
                    arb_hi_found = 1'b1;
                    arb_hi_idx   = PTR_W'(i);
                end
            end
        end
        arb_idx = arb_hi_found ? arb_hi_idx : arb_any_idx;
    end

    // Select the granted requester's byte lane
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                owner_data = req_data[8*i +: 8];
            end
        end
    end

    assign owner_valid = |(req_valid & grant);
    assign owner_last  = |(req_last & grant);
    assign hs          = (state == S_XFER) && owner_valid;
    // A commit closes on the packet's last byte or when the buffer is full
    assign xfer_end    = hs && (owner_last || (count == LAST_IDX));
    assign ack_expired = (ack_timer == TMR_LAST);
    assign start       = (|req_valid) && buf_in_ready;
    assign owner_inc   = (owner == PTR_LAST) ? '0 : owner + PTR_W'(1);

    // State register
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start)        state_nxt = S_XFER;
            S_WAIT_RDY: if (buf_in_ready) state_nxt = S_XFER;
            S_XFER:     if (xfer_end)     state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (buf_in_commit_ack) begin
                    state_nxt = split ? S_WAIT_RDY : S_IDLE;
                end else if (ack_expired) begin
                    state_nxt = S_IDLE;
                end
            end
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs: byte acceptance and busy flag
    always_comb begin
        req_ready = (state == S_XFER) ? grant : '0;
        busy      = (state != S_IDLE);
    end

    // Datapath: grant ownership, buffer writes, commit handshake, ack timer
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            grant             <= '0;
            rr_ptr            <= '0;
            owner             <= '0;
            count             <= '0;
            split             <= 1'b0;
            ack_timer         <= '0;
            buf_in_wren       <= 1'b0;
            buf_in_addr       <= '0;
            buf_in_data       <= '0;
            buf_in_commit     <= 1'b0;
            buf_in_commit_len <= '0;
            err_ack_timeout   <= 1'b0;
        end else begin
            buf_in_wren     <= 1'b0;
            err_ack_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        grant <= NUM_REQ'(1) << arb_idx;
                        owner <= arb_idx;
                        count <= '0;
                    end
                end
                S_XFER: begin
                    if (hs) begin
                        buf_in_wren <= 1'b1;
                        buf_in_addr <= count[8:0];
                        buf_in_data <= owner_data;
                        count       <= count + 10'd1;
                        if (xfer_end) begin
                            buf_in_commit     <= 1'b1;
                            buf_in_commit_len <= count + 10'd1;
                            split             <= !owner_last;
                            ack_timer         <= '0;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (buf_in_commit_ack) begin
                        buf_in_commit <= 1'b0;
                        if (split) begin
                            // Remainder of the packet stays with the same owner
                            count <= '0;
                        end else begin
                            grant  <= '0;
                            rr_ptr <= owner_inc;
                        end
                    end else if (ack_expired) begin
                        buf_in_commit   <= 1'b0;
                        err_ack_timeout <= 1'b1;
                        grant           <= '0;
                        rr_ptr          <= owner_inc;
                    end else begin
                        ack_timer <= ack_timer + TMR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
`default_nettype wire
